multicycle_ctrl: RTL and testbench



---
 rtl/multicycle_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multi-cycle processor control FSM: sequences fetch/decode/exec/mem/wb,
// drives datapath enables and selects, and owns the single memory port
// handshake with a watchdog that halts the core on a missing mem_ack.
module multicycle_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CW      = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       ir_write,
  output logic       ext_op,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       illegal,
  output logic       bus_err,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd7
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_SUB   = 2'd1;
  localparam logic [1:0] ALU_FUNCT = 2'd2;
  localparam logic [1:0] ALU_OR    = 2'd3;

  localparam logic [1:0] SRCB_REG  = 2'd0;
  localparam logic [1:0] SRCB_FOUR = 2'd1;
  localparam logic [1:0] SRCB_IMM  = 2'd2;
  localparam logic [1:0] SRCB_IMM4 = 2'd3;

  localparam logic [1:0] PC_SEQ    = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic            illegal_q, illegal_d;
  logic            bus_err_q, bus_err_d;
  logic            wait_st, ack, tmo, supported;

  // The ALU control decodes funct itself; this block only sequences.
  logic unused_funct;
  assign unused_funct = ^funct;

  // Memory is only requested in FETCH/MEM, so acks elsewhere are dropped.
  assign wait_st = (state_q == S_FETCH) || (state_q == S_MEM);
  assign ack     = wait_st && mem_ack;
  assign cnt_inc = cnt_q + 1'b1;
  // A late ack on the final allowed cycle still completes the access.
  assign tmo     = wait_st && !mem_ack && (cnt_inc == CW'(TIMEOUT));

  // Opcodes this controller knows how to sequence.
  always_comb begin
    supported = 1'b0;
    case (opcode)
      OP_RTYPE, OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU,
      OP_ANDI, OP_ORI, OP_LW, OP_SW: supported = 1'b1;
      default:                       supported = 1'b0;
    endcase
  end

  // Next state, watchdog counter and sticky error flags.
  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    illegal_d = illegal_q;
    bus_err_d = bus_err_q;
    unique case (state_q)
      S_FETCH: begin
        if (ack) begin
          state_d = S_DECODE;
        end else if (tmo) begin
          state_d   = S_HALT;
          bus_err_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_DECODE: begin
        if (!supported) begin
          illegal_d = 1'b1;
          state_d   = S_HALT;
        end else if (opcode == OP_J) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (opcode)
          OP_RTYPE, OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI: state_d = S_WB;
          OP_LW, OP_SW:                                 state_d = S_MEM;
          default:                                      state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (ack) begin
          state_d = (opcode == OP_SW) ? S_FETCH : S_WB;
        end else if (tmo) begin
          state_d   = S_HALT;
          bus_err_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_WB:    state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // State, counter and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Datapath controls; forced to idle while reset is held so an in-flight
  // memory request drops without waiting for a clock.
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PC_SEQ;
    ir_write   = 1'b0;
    ext_op     = 1'b1;
    alu_src_b  = SRCB_REG;
    alu_op     = ALU_ADD;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    if (rst_n) begin
      unique case (state_q)
        S_FETCH: begin
          mem_req   = 1'b1;
          alu_src_b = SRCB_FOUR;
          if (mem_ack) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
          end
        end
        S_DECODE: begin
          // ALU precomputes PC+4 + (imm<<2) for a possible branch.
          alu_src_b = SRCB_IMM4;
          if (opcode == OP_J) begin
            pc_write = 1'b1;
            pc_src   = PC_JUMP;
          end
        end
        S_EXEC: begin
          case (opcode)
            OP_RTYPE: alu_op = ALU_FUNCT;
            OP_ADDI, OP_ADDIU, OP_LW, OP_SW: alu_src_b = SRCB_IMM;
            OP_ANDI: begin
              alu_src_b = SRCB_IMM;
              ext_op    = 1'b0;
              alu_op    = ALU_FUNCT;
            end
            OP_ORI: begin
              alu_src_b = SRCB_IMM;
              ext_op    = 1'b0;
              alu_op    = ALU_OR;
            end
            OP_BEQ, OP_BNE: begin
              alu_op   = ALU_SUB;
              pc_src   = PC_BRANCH;
              pc_write = zero ^ (opcode == OP_BNE);
            end
            default: ;
          endcase
        end
        S_MEM: begin
          mem_req = 1'b1;
          iord    = 1'b1;
          mem_we  = (opcode == OP_SW);
        end
        S_WB: begin
          reg_write  = 1'b1;
          reg_dst    = (opcode == OP_RTYPE);
          mem_to_reg = (opcode == OP_LW);
        end
        default: ;
      endcase
    end
  end

  assign illegal = illegal_q;
  assign bus_err = bus_err_q;
  assign state   = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: each scenario queues the expected
// per-cycle control vector plus the mem_ack pattern, then drains the queue
// against the DUT one clock at a time.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic [2:0] st;
    logic       req;
    logic       iord;
    logic       we;
    logic       pcw;
    logic [1:0] pcs;
    logic       irw;
    logic       ext;
    logic [1:0] srcb;
    logic [1:0] aop;
    logic       rw;
    logic       rdst;
    logic       m2r;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n, zero, mem_ack;
  logic [5:0] opcode, funct;
  logic       mem_req, mem_we, iord, pc_write, ir_write, ext_op;
  logic       reg_write, reg_dst, mem_to_reg, illegal, bus_err;
  logic [1:0] pc_src, alu_src_b, alu_op;
  logic [2:0] state;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  bit   ackq[$];

  exp_t RST, F_WAIT, F_ACK, D_N, D_J, E_R, E_ADDI, E_ORI, E_ANDI;
  exp_t E_BT, E_BN, M_LW, M_SW, W_R, W_I, W_LW, HLT;

  always #5 clk = ~clk;

  multicycle_ctrl #(.TIMEOUT(4), .CW(8)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
    .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write),
    .ext_op(ext_op), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .illegal(illegal), .bus_err(bus_err), .state(state)
  );

  function automatic exp_t mk(input int st, req, io, we, pcw, pcs, irw,
                              ext, srcb, aop, rw, rdst, m2r);
    exp_t r;
    r.st = 3'(st); r.req = 1'(req); r.iord = 1'(io); r.we = 1'(we);
    r.pcw = 1'(pcw); r.pcs = 2'(pcs); r.irw = 1'(irw); r.ext = 1'(ext);
    r.srcb = 2'(srcb); r.aop = 2'(aop); r.rw = 1'(rw); r.rdst = 1'(rdst);
    r.m2r = 1'(m2r);
    return r;
  endfunction

  function automatic exp_t obs();
    exp_t r;
    r.st = state; r.req = mem_req; r.iord = iord; r.we = mem_we;
    r.pcw = pc_write; r.pcs = pc_src; r.irw = ir_write; r.ext = ext_op;
    r.srcb = alu_src_b; r.aop = alu_op; r.rw = reg_write; r.rdst = reg_dst;
    r.m2r = mem_to_reg;
    return r;
  endfunction

  //            st req io we pcw pcs irw ext srcb aop rw rdst m2r
  task automatic init_exp();
    RST    = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    F_WAIT = mk(0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    F_ACK  = mk(0, 1, 0, 0, 1, 0, 1, 1, 1, 0, 0, 0, 0);
    D_N    = mk(1, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0);
    D_J    = mk(1, 0, 0, 0, 1, 2, 0, 1, 3, 0, 0, 0, 0);
    E_R    = mk(2, 0, 0, 0, 0, 0, 0, 1, 0, 2, 0, 0, 0);
    E_ADDI = mk(2, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0);
    E_ORI  = mk(2, 0, 0, 0, 0, 0, 0, 0, 2, 3, 0, 0, 0);
    E_ANDI = mk(2, 0, 0, 0, 0, 0, 0, 0, 2, 2, 0, 0, 0);
    E_BT   = mk(2, 0, 0, 0, 1, 1, 0, 1, 0, 1, 0, 0, 0);
    E_BN   = mk(2, 0, 0, 0, 0, 1, 0, 1, 0, 1, 0, 0, 0);
    M_LW   = mk(3, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    M_SW   = mk(3, 1, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    W_R    = mk(4, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0);
    W_I    = mk(4, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0);
    W_LW   = mk(4, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 1);
    HLT    = mk(7, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
  endtask

  task automatic push(input exp_t e, input bit a);
    sb.push_back(e);
    ackq.push_back(a);
  endtask

  // Entered at posedge+1; drives ack for this cycle, samples at the negedge,
  // returns at posedge+1 of the next cycle.
  task automatic step(input bit a, output exp_t got);
    mem_ack = a;
    #4;
    got = obs();
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    exp_t got;
    rst_n = 1'b1; mem_ack = 1'b0; zero = 1'b0; opcode = 6'h00; funct = 6'h20;
    #2;
    rst_n = 1'b0;
    #1;
    got = obs();
    checks++;
    if (got !== RST) begin
      errors++; $display("FAIL reset_outputs got=%h exp=%h", got, RST);
    end
    checks++;
    if ({illegal, bus_err} !== 2'b00) begin
      errors++; $display("FAIL reset_flags got=%b exp=00", {illegal, bus_err});
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    exp_t got, e;
    opcode = 6'h00; funct = 6'h20;
    push(F_ACK, 1); push(D_N, 0); push(E_R, 0); push(W_R, 0);
    for (int i = 0; sb.size() > 0; i++) begin
      step(ackq.pop_front(), got); e = sb.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL add cyc%0d got=%h exp=%h", i, got, e); end
    end
    checks++;
    if (state !== 3'd0) begin errors++; $display("FAIL add_refetch got=%0d exp=0", state); end
  endtask

  task automatic test_imm_ext();
    exp_t got, e;
    // ORI, then ADDI, then ANDI back to back; imm16 = 0x8001 lives in the
    // datapath, only the extender mode is visible here.
    opcode = 6'h0D;
    push(F_ACK, 1); push(D_N, 0); push(E_ORI, 0); push(W_I, 0);
    for (int i = 0; sb.size() > 0; i++) begin
      if (i == 4) opcode = 6'h08;
      if (i == 8) opcode = 6'h0C;
      step(ackq.pop_front(), got); e = sb.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL imm_ext cyc%0d got=%h exp=%h", i, got, e); end
      if (i == 3) begin push(F_ACK, 1); push(D_N, 0); push(E_ADDI, 0); push(W_I, 0); end
      if (i == 7) begin push(F_ACK, 1); push(D_N, 0); push(E_ANDI, 0); push(W_I, 0); end
    end
  endtask

  task automatic test_lw_stall();
    exp_t got, e;
    // Ack on the 4th MEM cycle lands exactly when the watchdog would fire.
    opcode = 6'h23;
    push(F_ACK, 1); push(D_N, 0); push(E_ADDI, 0);
    push(M_LW, 0); push(M_LW, 0); push(M_LW, 0); push(M_LW, 1); push(W_LW, 0);
    for (int i = 0; sb.size() > 0; i++) begin
      step(ackq.pop_front(), got); e = sb.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL lw_stall cyc%0d got=%h exp=%h", i, got, e); end
    end
    checks++;
    if ({state, bus_err} !== 4'b0000) begin
      errors++; $display("FAIL lw_ack_wins got=%b exp=0000", {state, bus_err});
    end
  endtask

  task automatic test_back_to_back();
    exp_t got, e;
    // SW with one fetch wait cycle, then J.
    opcode = 6'h2B;
    push(F_WAIT, 0); push(F_ACK, 1); push(D_N, 0); push(E_ADDI, 0); push(M_SW, 1);
    push(F_ACK, 1); push(D_J, 0);
    for (int i = 0; sb.size() > 0; i++) begin
      if (i == 5) opcode = 6'h02;
      step(ackq.pop_front(), got); e = sb.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL b2b cyc%0d got=%h exp=%h", i, got, e); end
    end
    checks++;
    if (state !== 3'd0) begin errors++; $display("FAIL j_refetch got=%0d exp=0", state); end
  endtask

  task automatic test_branch();
    exp_t got, e;
    bit [5:0] ops [4]  = '{6'h04, 6'h05, 6'h04, 6'h05};
    bit       zs  [4]  = '{1'b1, 1'b1, 1'b0, 1'b0};
    for (int k = 0; k < 4; k++) begin
      opcode = ops[k]; zero = zs[k];
      push(F_ACK, 1); push(D_N, 0);
      push(((ops[k] == 6'h05) ^ zs[k]) ? E_BT : E_BN, 0);
      for (int i = 0; sb.size() > 0; i++) begin
        step(ackq.pop_front(), got); e = sb.pop_front(); checks++;
        if (got !== e) begin
          errors++; $display("FAIL branch%0d cyc%0d got=%h exp=%h", k, i, got, e);
        end
      end
    end
    zero = 1'b0;
  endtask

  task automatic test_timeout();
    exp_t got, e;
    opcode = 6'h00;
    push(F_WAIT, 0); push(F_WAIT, 0); push(F_WAIT, 0); push(F_WAIT, 0);
    push(HLT, 1); push(HLT, 0);
    for (int i = 0; sb.size() > 0; i++) begin
      step(ackq.pop_front(), got); e = sb.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL timeout cyc%0d got=%h exp=%h", i, got, e); end
    end
    checks++;
    if ({bus_err, illegal} !== 2'b10) begin
      errors++; $display("FAIL timeout_flags got=%b exp=10", {bus_err, illegal});
    end
    do_reset();
    checks++;
    if ({state, bus_err} !== 4'b0000) begin
      errors++; $display("FAIL timeout_clear got=%b exp=0000", {state, bus_err});
    end
  endtask

  task automatic test_illegal();
    exp_t got, e;
    opcode = 6'h3F;
    push(F_ACK, 1); push(D_N, 0); push(HLT, 0); push(HLT, 1);
    for (int i = 0; sb.size() > 0; i++) begin
      step(ackq.pop_front(), got); e = sb.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL illegal cyc%0d got=%h exp=%h", i, got, e); end
    end
    checks++;
    if ({illegal, bus_err} !== 2'b10) begin
      errors++; $display("FAIL illegal_flags got=%b exp=10", {illegal, bus_err});
    end
    do_reset();
    checks++;
    if ({state, illegal} !== 4'b0000) begin
      errors++; $display("FAIL illegal_clear got=%b exp=0000", {state, illegal});
    end
  endtask

  task automatic test_reset_mid_mem();
    exp_t got, e;
    opcode = 6'h23;
    push(F_ACK, 1); push(D_N, 0); push(E_ADDI, 0); push(M_LW, 0);
    for (int i = 0; sb.size() > 0; i++) begin
      step(ackq.pop_front(), got); e = sb.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL mid_mem cyc%0d got=%h exp=%h", i, got, e); end
    end
    #1;
    checks++;
    if ({state, mem_req, iord} !== 5'b01111) begin
      errors++; $display("FAIL mid_mem_pre got=%b exp=01111", {state, mem_req, iord});
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({state, mem_req} !== 4'b0000) begin
      errors++; $display("FAIL mid_mem_async got=%b exp=0000", {state, mem_req});
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    // Recovery: a clean R-type after the aborted load.
    opcode = 6'h00;
    push(F_ACK, 1); push(D_N, 0); push(E_R, 0); push(W_R, 0);
    for (int i = 0; sb.size() > 0; i++) begin
      step(ackq.pop_front(), got); e = sb.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL recover cyc%0d got=%h exp=%h", i, got, e); end
    end
  endtask

  initial begin
    init_exp();
    test_reset();
    test_add();
    test_imm_ext();
    test_lw_stall();
    test_back_to_back();
    test_branch();
    test_timeout();
    test_illegal();
    test_reset_mid_mem();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
